sound_cmd_master: RTL and testbench

Main-CPU-side initiator for the sound board's two inbound paths.
- Queues command bytes written by the main CPU and delivers them one at a time into the sound-board command latch (SND/IO_A/IO_DIN). It paces delivery on the latch-pending flag returned by the sound board.
- Runs a bus-request upload engine: holds BRQ and copies a byte stream from ROM into the 64 KB sound RAM using MWR/SDBEN writes.
- Sits between the main-CPU I/O decode / ROM loader and the sound board.

---
 rtl/sound_cmd_master_if.sv | 47 ++++
 rtl/sound_cmd_master.sv | 218 +++++++++++++++++++++
 tb/tb_sound_cmd_master.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sound_cmd_master_if.sv
// Bus bundle between the sound command master and its environment
// (main-CPU I/O decode, ROM loader, sound board).
interface sound_cmd_master_if #(
    parameter int unsigned FIFO_DEPTH = 8
) ();
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          CMD_WR;
    logic [7:0]    CMD_DATA;
    logic [CW-1:0] FIFO_COUNT;
    logic          FIFO_FULL;
    logic          OVERFLOW;
    logic          LATCH_BUSY;
    logic          SND;
    logic [7:0]    IO_A;
    logic [7:0]    IO_DIN;
    logic          UPLOAD_START;
    logic [23:0]   UPLOAD_SRC;
    logic [15:0]   UPLOAD_DST;
    logic [16:0]   UPLOAD_LEN;
    logic [23:0]   ROM_ADDR;
    logic          ROM_RD;
    logic [7:0]    ROM_DATA;
    logic          ROM_VALID;
    logic          BRQ;
    logic [19:0]   A;
    logic [15:0]   DOUT;
    logic [1:0]    BYTE_SEL;
    logic          MWR;
    logic          SDBEN;
    logic          UPLOAD_BUSY;
    logic          UPLOAD_DONE;

    modport master (
        input  CMD_WR, CMD_DATA, LATCH_BUSY, UPLOAD_START, UPLOAD_SRC, UPLOAD_DST,
               UPLOAD_LEN, ROM_DATA, ROM_VALID,
        output FIFO_COUNT, FIFO_FULL, OVERFLOW, SND, IO_A, IO_DIN, ROM_ADDR, ROM_RD,
               BRQ, A, DOUT, BYTE_SEL, MWR, SDBEN, UPLOAD_BUSY, UPLOAD_DONE
    );

    modport slave (
        output CMD_WR, CMD_DATA, LATCH_BUSY, UPLOAD_START, UPLOAD_SRC, UPLOAD_DST,
               UPLOAD_LEN, ROM_DATA, ROM_VALID,
        input  FIFO_COUNT, FIFO_FULL, OVERFLOW, SND, IO_A, IO_DIN, ROM_ADDR, ROM_RD,
               BRQ, A, DOUT, BYTE_SEL, MWR, SDBEN, UPLOAD_BUSY, UPLOAD_DONE
    );
endinterface

// File: rtl/sound_cmd_master.sv
// Main-CPU side initiator for the sound board: paced command-latch delivery
// from a FIFO, plus a BRQ-held ROM-to-sound-RAM upload engine.
module sound_cmd_master #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BRQ_SETTLE = 4,
    parameter int unsigned ACK_BLANK  = 2
) (
    input  logic               CLK_32M,
    input  logic               RESET,
    sound_cmd_master_if.master bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = 8;

    typedef enum logic [2:0] {
        IDLE, CMD_SEND, CMD_WAIT, UP_REQ, UP_FETCH, UP_WRITE, UP_END
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [23:0]   src_q, src_d;
    logic [15:0]   dst_q, dst_d;
    logic [16:0]   rem_q, rem_d;

    logic          snd_q, snd_d;
    logic [7:0]    io_din_q, io_din_d;
    logic          rom_rd_q, rom_rd_d;
    logic [23:0]   rom_addr_q, rom_addr_d;
    logic          brq_q, brq_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          mwr_q, mwr_d;
    logic          sdben_q, sdben_d;
    logic [19:0]   a_q, a_d;
    logic [15:0]   dout_q, dout_d;
    logic [1:0]    bsel_q, bsel_d;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          push, pop;

    // FIFO bookkeeping; the head is popped during the SND cycle
    always_comb begin
        push       = bus.CMD_WR && !full_q;
        pop        = (state_q == CMD_SEND);
        wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push) - CW'(pop);
        full_d     = (count_d == CW'(FIFO_DEPTH));
        overflow_d = overflow_q | (bus.CMD_WR & full_q);
    end

    always_ff @(posedge CLK_32M) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.CMD_DATA;
    end

    // Next state; outputs are computed for the state being entered and registered
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        dst_d      = dst_q;
        rem_d      = rem_q;
        snd_d      = 1'b0;
        io_din_d   = io_din_q;
        rom_rd_d   = 1'b0;
        rom_addr_d = rom_addr_q;
        brq_d      = brq_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mwr_d      = 1'b0;
        sdben_d    = 1'b0;
        a_d        = a_q;
        dout_d     = dout_q;
        bsel_d     = bsel_q;

        case (state_q)
            IDLE: begin
                if (bus.UPLOAD_START) begin
                    if (bus.UPLOAD_LEN == 17'd0) begin
                        done_d = 1'b1;
                    end else begin
                        src_d   = bus.UPLOAD_SRC;
                        dst_d   = bus.UPLOAD_DST;
                        rem_d   = bus.UPLOAD_LEN;
                        cnt_d   = '0;
                        brq_d   = 1'b1;
                        busy_d  = 1'b1;
                        state_d = UP_REQ;
                    end
                end else if (count_q != '0 && !bus.LATCH_BUSY) begin
                    snd_d    = 1'b1;
                    io_din_d = fifo_mem[rd_ptr_q];
                    state_d  = CMD_SEND;
                end
            end
            CMD_SEND: begin
                cnt_d   = '0;
                state_d = CMD_WAIT;
            end
            CMD_WAIT: begin
                // ignore LATCH_BUSY until the sound board's feedback can have arrived
                if (cnt_q < TW'(ACK_BLANK)) begin
                    cnt_d = cnt_q + TW'(1);
                end else if (!bus.LATCH_BUSY) begin
                    state_d = IDLE;
                end
            end
            UP_REQ: begin
                if (cnt_q >= TW'(BRQ_SETTLE - 1)) begin
                    rom_rd_d   = 1'b1;
                    rom_addr_d = src_q;
                    state_d    = UP_FETCH;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            UP_FETCH: begin
                if (bus.ROM_VALID) begin
                    mwr_d   = 1'b1;
                    sdben_d = 1'b1;
                    a_d     = {4'h0, dst_q};
                    dout_d  = {bus.ROM_DATA, bus.ROM_DATA};
                    bsel_d  = dst_q[0] ? 2'b10 : 2'b01;
                    state_d = UP_WRITE;
                end
            end
            UP_WRITE: begin
                src_d = src_q + 24'd1;
                dst_d = dst_q + 16'd1;
                rem_d = rem_q - 17'd1;
                if (rem_q == 17'd1) begin
                    brq_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = UP_END;
                end else begin
                    rom_rd_d   = 1'b1;
                    rom_addr_d = src_q + 24'd1;
                    state_d    = UP_FETCH;
                end
            end
            UP_END:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            snd_q      <= 1'b0;
            io_din_q   <= '0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            brq_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mwr_q      <= 1'b0;
            sdben_q    <= 1'b0;
            a_q        <= '0;
            dout_q     <= '0;
            bsel_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            snd_q      <= snd_d;
            io_din_q   <= io_din_d;
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
            brq_q      <= brq_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mwr_q      <= mwr_d;
            sdben_q    <= sdben_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            bsel_q     <= bsel_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.FIFO_COUNT  = count_q;
    assign bus.FIFO_FULL   = full_q;
    assign bus.OVERFLOW    = overflow_q;
    assign bus.SND         = snd_q;
    assign bus.IO_A        = 8'h00;
    assign bus.IO_DIN      = io_din_q;
    assign bus.ROM_ADDR    = rom_addr_q;
    assign bus.ROM_RD      = rom_rd_q;
    assign bus.BRQ         = brq_q;
    assign bus.A           = a_q;
    assign bus.DOUT        = dout_q;
    assign bus.BYTE_SEL    = bsel_q;
    assign bus.MWR         = mwr_q;
    assign bus.SDBEN       = sdben_q;
    assign bus.UPLOAD_BUSY = busy_q;
    assign bus.UPLOAD_DONE = done_q;
endmodule

// File: tb/tb_sound_cmd_master.sv
// Self-checking bench for sound_cmd_master: sound-latch and ROM models in a
// monitor process, scenario tasks comparing against queue-based expectations.
module tb_sound_cmd_master;
    localparam int unsigned DEPTH  = 8;
    localparam int          SETTLE = 4;
    localparam int unsigned BLANK  = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sound_cmd_master_if #(.FIFO_DEPTH(DEPTH)) bus ();

    sound_cmd_master #(
        .FIFO_DEPTH(DEPTH),
        .BRQ_SETTLE(SETTLE),
        .ACK_BLANK (BLANK)
    ) dut (
        .CLK_32M(clk),
        .RESET  (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // observation logs and environment models
    int          cyc = 0;
    logic [7:0]  snd_data[$];
    int          snd_cyc[$];
    logic [19:0] wr_a[$];
    logic [15:0] wr_d[$];
    logic [1:0]  wr_bs[$];
    int          done_cnt = 0;
    int          brq_hi_cycles = 0;
    int          brq_rise = 0;
    logic        brq_prev = 1'b0;
    int          rom_rd_cnt = 0;
    int          snd_brq_bad = 0;
    int          io_a_bad = 0;
    int          settle_bad = 0;
    bit          auto_mode = 0;
    bit          hold_busy = 0;
    bit          raise_pend = 0;
    int          busy_timer = 0;
    int          rom_lat = 3;
    int          rom_due = -1;
    logic [23:0] rom_pend_addr = '0;
    logic [7:0]  rom_mem [int];

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        if (rom_mem.exists(int'(a))) return rom_mem[int'(a)];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h3C;
    endfunction

    initial begin : monitor
        bus.LATCH_BUSY = 1'b0;
        bus.ROM_VALID  = 1'b0;
        bus.ROM_DATA   = 8'h00;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (bus.SND === 1'b1) begin
                snd_data.push_back(bus.IO_DIN);
                snd_cyc.push_back(cyc);
                if (bus.IO_A !== 8'h00) io_a_bad++;
                if (bus.BRQ !== 1'b0) snd_brq_bad++;
            end
            if (bus.BRQ === 1'b1 && brq_prev !== 1'b1) brq_rise = cyc;
            if (bus.BRQ === 1'b1) brq_hi_cycles++;
            if (bus.MWR === 1'b1) begin
                wr_a.push_back(bus.A);
                wr_d.push_back(bus.DOUT);
                wr_bs.push_back(bus.BYTE_SEL);
                if (bus.BRQ !== 1'b1 || bus.SDBEN !== 1'b1 || (cyc - brq_rise) < SETTLE)
                    settle_bad++;
            end
            brq_prev = bus.BRQ;
            if (bus.UPLOAD_DONE === 1'b1) done_cnt++;
            // sound latch: goes busy one cycle after each SND, stays busy 10 cycles
            if (raise_pend) begin
                busy_timer = 10;
                raise_pend = 0;
            end else if (busy_timer > 0) begin
                busy_timer--;
            end
            if (auto_mode && bus.SND === 1'b1) raise_pend = 1;
            bus.LATCH_BUSY = hold_busy || (busy_timer > 0);
            // ROM: one outstanding read, data valid rom_lat cycles later
            bus.ROM_VALID = 1'b0;
            if (rom_due == cyc) begin
                bus.ROM_VALID = 1'b1;
                bus.ROM_DATA  = rom_byte(rom_pend_addr);
                rom_due = -1;
            end
            if (bus.ROM_RD === 1'b1) begin
                rom_pend_addr = bus.ROM_ADDR;
                rom_due = cyc + rom_lat;
                rom_rd_cnt++;
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic clear_logs();
        snd_data.delete();
        snd_cyc.delete();
        wr_a.delete();
        wr_d.delete();
        wr_bs.delete();
        done_cnt = 0;
        brq_hi_cycles = 0;
        rom_rd_cnt = 0;
    endtask

    task automatic wr_cmd(input logic [7:0] d);
        bus.CMD_WR   = 1'b1;
        bus.CMD_DATA = d;
        tick();
        bus.CMD_WR   = 1'b0;
    endtask

    task automatic start_upload(input logic [23:0] src, input logic [15:0] dst,
                                input logic [16:0] len);
        bus.UPLOAD_SRC   = src;
        bus.UPLOAD_DST   = dst;
        bus.UPLOAD_LEN   = len;
        bus.UPLOAD_START = 1'b1;
        tick();
        bus.UPLOAD_START = 1'b0;
    endtask

    task automatic wait_snd(input int n, input int limit);
        for (int t = 0; t < limit && snd_data.size() < n; t++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        n_checks++;
        if ({bus.SND, bus.ROM_RD, bus.MWR, bus.SDBEN, bus.UPLOAD_DONE} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b expected 00000",
                     {bus.SND, bus.ROM_RD, bus.MWR, bus.SDBEN, bus.UPLOAD_DONE});
        end
        n_checks++;
        if ({bus.BRQ, bus.UPLOAD_BUSY, bus.OVERFLOW, bus.FIFO_FULL, bus.FIFO_COUNT} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_status: brq=%b busy=%b ovf=%b full=%b count=%0d expected all 0",
                     bus.BRQ, bus.UPLOAD_BUSY, bus.OVERFLOW, bus.FIFO_FULL, bus.FIFO_COUNT);
        end
        n_checks++;
        if ({bus.IO_A, bus.IO_DIN, bus.A, bus.DOUT, bus.BYTE_SEL, bus.ROM_ADDR} !== 78'b0) begin
            n_fail++;
            $display("FAIL reset_buses: io_a=%h io_din=%h a=%h dout=%h bs=%b rom_addr=%h expected 0",
                     bus.IO_A, bus.IO_DIN, bus.A, bus.DOUT, bus.BYTE_SEL, bus.ROM_ADDR);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_cmd();
        clear_logs();
        wr_cmd(8'h5A);
        wait_snd(1, 30);
        tick(10);
        n_checks++;
        if (snd_data.size() != 1) begin
            n_fail++;
            $display("FAIL single_snd_count: got %0d expected 1", snd_data.size());
        end
        n_checks++;
        if (snd_data[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL single_snd_data: got %h expected 5a", snd_data[0]);
        end
        n_checks++;
        if (bus.FIFO_COUNT !== 4'd0) begin
            n_fail++;
            $display("FAIL single_count: got %0d expected 0", bus.FIFO_COUNT);
        end
    endtask

    task automatic test_paced();
        logic [7:0] exp_q[$];
        clear_logs();
        auto_mode = 1;
        for (int i = 1; i <= 3; i++) begin
            exp_q.push_back(8'(i));
            wr_cmd(8'(i));
        end
        wait_snd(3, 300);
        n_checks++;
        if (snd_data.size() != 3) begin
            n_fail++;
            $display("FAIL paced_count: got %0d expected 3", snd_data.size());
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (snd_data[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL paced_data[%0d]: got %h expected %h", i, snd_data[i], exp_q[i]);
            end
        end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (snd_cyc[i] - snd_cyc[i-1] < 10) begin
                n_fail++;
                $display("FAIL paced_spacing[%0d]: got %0d cycles expected >= 10", i,
                         snd_cyc[i] - snd_cyc[i-1]);
            end
        end
        auto_mode = 0;
        tick(15);
    endtask

    task automatic test_overflow();
        logic [7:0] exp_q[$];
        bit         exp_ovf = 0;
        clear_logs();
        hold_busy = 1;
        tick(2);
        for (int i = 0; i < 9; i++) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(8'(8'h10 + i));
            else exp_ovf = 1;
            wr_cmd(8'(8'h10 + i));
        end
        tick();
        n_checks++;
        if (bus.FIFO_COUNT !== 4'(exp_q.size())) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d expected %0d", bus.FIFO_COUNT, exp_q.size());
        end
        n_checks++;
        if (bus.FIFO_FULL !== (exp_q.size() == DEPTH)) begin
            n_fail++;
            $display("FAIL ovf_full: got %b expected 1", bus.FIFO_FULL);
        end
        n_checks++;
        if (bus.OVERFLOW !== exp_ovf) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b expected %b", bus.OVERFLOW, exp_ovf);
        end
        hold_busy = 0;
        wait_snd(exp_q.size(), 300);
        tick(30);
        n_checks++;
        if (snd_data.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ovf_delivered: got %0d expected %0d", snd_data.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (snd_data[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ovf_data[%0d]: got %h expected %h", i, snd_data[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random_cmds();
        logic [7:0] exp_q[$];
        clear_logs();
        auto_mode = 1;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            exp_q.push_back(d);
            wr_cmd(d);
            tick($urandom_range(0, 3));
        end
        wait_snd(6, 500);
        n_checks++;
        if (snd_data.size() != 6) begin
            n_fail++;
            $display("FAIL rnd_count: got %0d expected 6", snd_data.size());
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (snd_data[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rnd_data[%0d]: got %h expected %h", i, snd_data[i], exp_q[i]);
            end
        end
        auto_mode = 0;
        tick(15);
    endtask

    task automatic run_upload_and_check(input string name, input logic [23:0] src,
                                        input logic [15:0] dst, input int len, input int lat);
        clear_logs();
        rom_lat = lat;
        start_upload(src, dst, 17'(len));
        for (int t = 0; t < len * (lat + 10) + 60 && done_cnt == 0; t++) tick();
        tick(5);
        n_checks++;
        if (wr_a.size() != len) begin
            n_fail++;
            $display("FAIL %s_writes: got %0d expected %0d", name, wr_a.size(), len);
        end
        for (int i = 0; i < len; i++) begin
            logic [15:0] ea;
            logic [7:0]  eb;
            ea = 16'(dst + 16'(i));
            eb = rom_byte(24'(src + 24'(i)));
            n_checks++;
            if (wr_a[i] !== {4'h0, ea} || wr_d[i] !== {eb, eb} ||
                wr_bs[i] !== (ea[0] ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL %s_wr[%0d]: got a=%h d=%h bs=%b expected a=%h d=%h bs=%b", name, i,
                         wr_a[i], wr_d[i], wr_bs[i], {4'h0, ea}, {eb, eb}, ea[0] ? 2'b10 : 2'b01);
            end
        end
        n_checks++;
        if (done_cnt != 1 || bus.BRQ !== 1'b0 || bus.UPLOAD_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: done=%0d brq=%b busy=%b expected 1 0 0", name,
                     done_cnt, bus.BRQ, bus.UPLOAD_BUSY);
        end
        n_checks++;
        if (settle_bad != 0) begin
            n_fail++;
            $display("FAIL %s_settle: %0d writes without %0d cycles of BRQ", name, settle_bad, SETTLE);
        end
    endtask

    task automatic test_upload_spec();
        rom_mem[32'h1000] = 8'hAA;
        rom_mem[32'h1001] = 8'hBB;
        rom_mem[32'h1002] = 8'hCC;
        run_upload_and_check("up_spec", 24'h001000, 16'hFFFE, 3, 3);
    endtask

    task automatic test_upload_random();
        for (int k = 0; k < 3; k++) begin
            logic [23:0] src;
            src = (k == 0) ? 24'hFFFFFE : 24'($urandom);
            run_upload_and_check("up_rnd", src, 16'($urandom), int'($urandom_range(1, 6)),
                                 int'($urandom_range(1, 4)));
        end
    endtask

    task automatic test_zero_len();
        clear_logs();
        start_upload(24'h123456, 16'h0100, 17'd0);
        n_checks++;
        if (bus.UPLOAD_DONE !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_done: got %b expected 1 one cycle after start", bus.UPLOAD_DONE);
        end
        tick(10);
        n_checks++;
        if (done_cnt != 1 || brq_hi_cycles != 0 || rom_rd_cnt != 0) begin
            n_fail++;
            $display("FAIL zero_quiet: done=%0d brq_cycles=%0d rom_rds=%0d expected 1 0 0",
                     done_cnt, brq_hi_cycles, rom_rd_cnt);
        end
    endtask

    task automatic test_reset_mid_upload();
        clear_logs();
        rom_lat = 3;
        start_upload(24'h002000, 16'h0100, 17'd10);
        for (int t = 0; t < 100 && wr_a.size() < 2; t++) tick();
        wr_cmd(8'h77);
        n_checks++;
        if (bus.FIFO_COUNT !== 4'd1 || bus.BRQ !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_enqueue: count=%0d brq=%b expected 1 1", bus.FIFO_COUNT, bus.BRQ);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (bus.BRQ !== 1'b0 || bus.UPLOAD_BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_brq: brq=%b busy=%b expected 0 0", bus.BRQ, bus.UPLOAD_BUSY);
        end
        rst = 1'b0;
        n_checks++;
        if (bus.FIFO_COUNT !== 4'd0 || bus.OVERFLOW !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_fifo: count=%0d ovf=%b expected 0 0", bus.FIFO_COUNT, bus.OVERFLOW);
        end
        tick(30);
        n_checks++;
        if (done_cnt != 0 || snd_data.size() != 0) begin
            n_fail++;
            $display("FAIL mid_after: done=%0d snd=%0d expected 0 0", done_cnt, snd_data.size());
        end
    endtask

    initial begin : driver
        rst              = 1'b1;
        bus.CMD_WR       = 1'b0;
        bus.CMD_DATA     = 8'h00;
        bus.UPLOAD_START = 1'b0;
        bus.UPLOAD_SRC   = '0;
        bus.UPLOAD_DST   = '0;
        bus.UPLOAD_LEN   = '0;
        test_reset();
        test_single_cmd();
        test_paced();
        test_overflow();
        test_random_cmds();
        test_upload_spec();
        test_upload_random();
        test_zero_len();
        test_reset_mid_upload();
        n_checks++;
        if (snd_brq_bad != 0 || io_a_bad != 0) begin
            n_fail++;
            $display("FAIL snd_invariants: snd_with_brq=%0d bad_io_a=%0d expected 0 0",
                     snd_brq_bad, io_a_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
